mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
// - Multiply/divide unit of the E stage; consumes the start/md/mudeop/rs/rt issue signals produced by the D->E pipeline register.
// - Owns the HI/LO registers. Runs mult/multu/div/divu as multi-cycle operations with a busy handshake. Serves mthi/mtlo/mfhi/mflo.
// - The hazard unit stalls D on (start | busy) when the D instruction is an MD-class instruction.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for mult/multu (>=1)
// - DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// - clk       in   1   system clock, rising edge
// - reset_n   in   1   asynchronous reset, active-low
// - start     in   1   1-cycle issue pulse for mult/multu/div/divu
// - md        in   1   HI/LO access instruction in E (mthi/mtlo/mfhi/mflo)
// - mudeop    in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo
// - rs        in   32  forwarded rs operand (dividend / multiplicand / mt source)
// - rt        in   32  forwarded rt operand (divisor / multiplier)
// - cancel    in   1   exception/interrupt taken in M this cycle; blocks issue and HI/LO writes
// - busy      out  1   operation in progress
// - hi        out  32  HI register
// - lo        out  32  LO register
// - rdata     out  32  mfhi -> hi, mflo -> lo, otherwise 0 (combinational)
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, cnt=0, hi=0, lo=0, busy=0, pending regs=0. Takes effect immediately, including mid-operation; the pending result is discarded.
// - FSM states: IDLE, RUN.
//   - IDLE -> RUN on an edge with start=1, cancel=0, mudeop[2]=0.
//     - Latch cnt = (mult? MULT_CYCLES : DIV_CYCLES) - 1.
//     - Latch the full result into pend_hi/pend_lo, computed from that cycle's rs/rt.
//   - RUN with cnt!=0: decrement cnt.
//   - RUN with cnt==0: hi<=pend_hi, lo<=pend_lo, -> IDLE.
// - busy = (state==RUN), registered. It rises on the edge after start and stays high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). HI/LO are updated on the edge where busy falls.
// - Arithmetic:
//   - mult: signed 32x32->64 {hi,lo}.
//   - multu: unsigned 32x32->64 {hi,lo}.
//   - div: lo=quotient, hi=remainder, truncating toward zero; remainder takes the sign of the dividend.
//   - divu: unsigned quotient/remainder.
//   - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
// - Divide by zero (rt=0, div or divu): full busy period is still spent; HI/LO are left unchanged at completion.
// - mthi/mtlo: when md=1, cancel=0, state=IDLE, write hi (100) or lo (101) <= rs at the edge.
//   - md writes while RUN are ignored; upstream stalls guarantee this never occurs.
// - mfhi/mflo: rdata reflects the current hi/lo with no bypass of the pending result (upstream stalls until busy=0).
// - start while RUN: ignored, no restart. start with mudeop[2]=1: ignored. start and md both set: start wins.
// - cancel: gates issue and mt writes in the same cycle only. Once RUN, the operation always completes (it belongs to an older, committed instruction).
// STRUCTURE
// - Package mdu_pkg:
//   - mudeop localparams (OP_MULT..OP_MFLO).
//   - state enum (ST_IDLE, ST_RUN).
//   - Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
// - Single module. The 64-bit product and the signed/unsigned quotient and remainder are computed combinationally at issue into pend_*; the latency is modelled by the counter.
// - One natural sub-module: mdu_arith (pure combinational; mudeop, rs, rt -> res_hi, res_lo, div0).
// TESTING
// - mult rs=0xFFFFFFFE(-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
// - multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
// - div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
// - divu with rt=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
// - start with cancel=1 -> busy stays 0, HI/LO unchanged. mtlo with cancel=1 -> lo unchanged.
// - reset_n low during cycle 3 of a mult -> busy=0, hi=lo=0 immediately; a fresh mult after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, FSM state type and counter sizing for the multiply/divide unit.
package mdu_pkg;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MFHI  = 3'b110;
   localparam logic [2:0] OP_MFLO  = 3'b111;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b ? a : b) + 1);
   endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit product and signed/unsigned quotient/remainder for one issue.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  mudeop,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);
   logic signed [63:0] prod_s;
   logic [63:0] prod_u, prod;
   logic        sgn;
   logic [31:0] a, b, bd, q, r, quo, rem;
   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      prod_u = {32'b0, rs} * {32'b0, rt};
      prod   = mudeop[0] ? prod_u : prod_s;
      sgn    = ~mudeop[0];
      a      = sgn & rs[31] ? -rs : rs;
      b      = sgn & rt[31] ? -rt : rt;
      bd     = b == 32'd0 ? 32'd1 : b;
      q      = a / bd;
      r      = a % bd;
      quo    = sgn & (rs[31] ^ rt[31]) ? -q : q;
      rem    = sgn & rs[31] ? -r : r;
      res_hi = mudeop[1] ? rem : prod[63:32];
      res_lo = mudeop[1] ? quo : prod[31:0];
      div0   = mudeop[1] & (rt == 32'd0);
   end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning HI/LO; results are computed at issue and
// committed after a fixed busy period counted down by cnt_q.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        md,
   input  logic [2:0]  mudeop,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);
   localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic        pend_div0_q, pend_div0_d;
   logic [31:0] res_hi, res_lo;
   logic        div0, issue, mt, run, done;

   mdu_arith u_arith (
      .mudeop (mudeop),
      .rs     (rs),
      .rt     (rt),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .div0   (div0)
   );

   always_comb begin
      run         = state_q == ST_RUN;
      issue       = !run & start & ~cancel & ~mudeop[2];
      mt          = !run & md & ~cancel & (mudeop[2:1] == 2'b10);
      done        = run & (cnt_q == '0);
      state_d     = issue ? ST_RUN : done ? ST_IDLE : state_q;
      cnt_d       = issue ? (mudeop[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1))
                  : run & !done ? cnt_q - CW'(1) : cnt_q;
      pend_hi_d   = issue ? res_hi : pend_hi_q;
      pend_lo_d   = issue ? res_lo : pend_lo_q;
      pend_div0_d = issue ? div0 : pend_div0_q;
      hi_d        = done & ~pend_div0_q ? pend_hi_q : mt & ~mudeop[0] ? rs : hi_q;
      lo_d        = done & ~pend_div0_q ? pend_lo_q : mt & mudeop[0] ? rs : lo_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         pend_hi_q   <= '0;
         pend_lo_q   <= '0;
         pend_div0_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         pend_hi_q   <= pend_hi_d;
         pend_lo_q   <= pend_lo_d;
         pend_div0_q <= pend_div0_d;
      end
   end

   assign busy  = state_q == ST_RUN;
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign rdata = md & (mudeop == OP_MFHI) ? hi_q : md & (mudeop == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with hand-computed HI/LO values and busy-period lengths.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, md = 1'b0, cancel = 1'b0;
   logic [2:0]  mudeop = 3'b0;
   logic [31:0] rs = 32'b0, rt = 32'b0;
   logic        busy;
   logic [31:0] hi, lo, rdata;
   int          n_chk = 0, n_fail = 0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .md(md), .mudeop(mudeop),
      .rs(rs), .rt(rt), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_idle(input string tag, input int first, input int cyc);
      int n = first;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_cycles"}, 64'(n), 64'(cyc));
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc);
      @(negedge clk);
      start = 1'b1; mudeop = op; rs = a; rt = b;
      @(negedge clk);
      start = 1'b0;
      wait_idle(tag, 0, cyc);
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      md = 1'b1; mudeop = op; rs = a;
      @(negedge clk);
      md = 1'b0;
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk_hilo("rst", 32'h0, 32'h0);
      #20 reset_n = 1'b1;

      run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 5);
      chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
      md = 1'b1; mudeop = OP_MFHI; #1;
      chk("mfhi", 64'(rdata), 64'hFFFFFFFF);
      mudeop = OP_MFLO; #1;
      chk("mflo", 64'(rdata), 64'hFFFFFFFA);
      md = 1'b0; #1;
      chk("rdata_idle", 64'(rdata), 64'h0);

      run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
      chk_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
      run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10);
      chk_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFFFFFE, 10);
      chk_hilo("div_negdiv", 32'h00000001, 32'hFFFFFFFD);
      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
      chk_hilo("div_ovf", 32'h0, 32'h80000000);
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 10);
      chk_hilo("divu", 32'd2, 32'd14);

      mt(OP_MTHI, 32'h1234);
      mt(OP_MTLO, 32'h5678);
      chk_hilo("mt", 32'h1234, 32'h5678);
      run_op("divu0", OP_DIVU, 32'd99, 32'd0, 10);
      chk_hilo("divu0", 32'h1234, 32'h5678);

      @(negedge clk);
      cancel = 1'b1; start = 1'b1; mudeop = OP_MULT; rs = 32'd2; rt = 32'd3;
      @(negedge clk);
      start = 1'b0;
      chk("cancel_busy", 64'(busy), 64'(0));
      md = 1'b1; mudeop = OP_MTLO; rs = 32'hDEAD;
      @(negedge clk);
      md = 1'b0; cancel = 1'b0;
      @(negedge clk);
      chk("cancel_busy2", 64'(busy), 64'(0));
      chk_hilo("cancel", 32'h1234, 32'h5678);

      @(negedge clk);
      start = 1'b1; mudeop = OP_MULT; rs = 32'd2; rt = 32'd3;
      @(negedge clk);
      mudeop = OP_DIV; rs = 32'd100; rt = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("restart", 1, 5);
      chk_hilo("restart", 32'h0, 32'd6);

      mt(OP_MTHI, 32'hAAAA);
      @(negedge clk);
      start = 1'b1; mudeop = OP_MULT; rs = 32'd5; rt = 32'd6;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk_hilo("arst", 32'h0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op("post_rst", OP_MULT, 32'd5, 32'd6, 5);
      chk_hilo("post_rst", 32'h0, 32'd30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
